// File: rtl/cas_recorder.sv
// -----------------------------------------------------------------------------
// cas_recorder
//
// Records the CoCo cassette-out signal (6-bit sound DAC) into an external
// SRAM as bytes. The DAC level is squared up by a hysteresis comparator on
// every Q-cycle tick (ce_q). Rising edges are timed by an 11-bit period
// counter, and each timed period becomes one bit: a short period (2400 Hz) is
// a 1 and a long period (1200 Hz) is a 0. Bits are assembled LSB first, and
// every completed byte is written to SRAM through a one-clock write strobe.
//
// Ports
//   clk         system clock (clk_sys), rising edge
//   reset_n     synchronous active-low reset
//   ce_q        one-clk pulse per CoCo Q cycle
//   en          cassette motor relay; 1 = recording allowed
//   rewind      level; clears address, count and flags
//   dac_in      6-bit DAC value
//   ram_addr    SRAM write address
//   ram_data    SRAM write data
//   ram_we      one-clk write strobe
//   byte_count  bytes written since the last rewind or reset
//   overflow    sticky; the byte at MAX_ADDR has been written
//   busy        high in ARM or RUN
// -----------------------------------------------------------------------------
module cas_recorder #(
  parameter logic [5:0]  THRESH   = 6'd32,
  parameter logic [5:0]  HYST     = 6'd4,
  parameter logic [10:0] MIN_PER  = 11'd200,
  parameter logic [10:0] SPLIT    = 11'd560,
  parameter logic [10:0] MAX_PER  = 11'd1500,
  parameter logic [15:0] MAX_ADDR = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce_q,
  input  logic        en,
  input  logic        rewind,
  input  logic [5:0]  dac_in,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_data,
  output logic        ram_we,
  output logic [15:0] byte_count,
  output logic        overflow,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    FULL = 2'd3
  } state_t;

  state_t      state;
  logic        level;
  logic [10:0] per_cnt;
  logic [7:0]  shreg;
  logic [2:0]  bit_cnt;

  logic        at_hi;
  logic        at_lo;
  logic        rise;
  logic [11:0] period;
  logic        per_glitch;
  logic        per_short;
  logic        per_timeout;
  logic [10:0] per_next;
  logic [7:0]  byte_next;

  always_comb begin
    // Comparisons are done 7 bits wide so THRESH +/- HYST never wraps.
    at_hi       = {1'b0, dac_in} >= ({1'b0, THRESH} + {1'b0, HYST});
    at_lo       = ({1'b0, dac_in} + {1'b0, HYST}) <= {1'b0, THRESH};
    // A 0->1 comparator change can only happen when at_hi is set on a tick.
    rise        = ce_q && !level && at_hi;
    // The edge tick itself completes the period, so the measured length is
    // the counter value plus one (ticks since the previous accepted edge).
    period      = {1'b0, per_cnt} + 12'd1;
    per_glitch  = period < {1'b0, MIN_PER};
    per_short   = period < {1'b0, SPLIT};
    per_timeout = per_cnt == MAX_PER;
    per_next    = (per_cnt == '1) ? per_cnt : per_cnt + 11'd1;
    byte_next   = {per_short, shreg[7:1]};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      level      <= 1'b0;
      per_cnt    <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
      ram_addr   <= '0;
      ram_data   <= '0;
      ram_we     <= 1'b0;
      byte_count <= '0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      ram_we <= 1'b0;

      if (ce_q) begin
        if (at_hi) begin
          level <= 1'b1;
        end else if (at_lo) begin
          level <= 1'b0;
        end
        per_cnt <= per_next;
      end

      case (state)
        IDLE: begin
          if (en) begin
            state   <= ARM;
            busy    <= 1'b1;
            per_cnt <= '0;
          end
        end

        ARM: begin
          if (!en) begin
            state   <= IDLE;
            busy    <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
          end else if (rise) begin
            // Reference edge: starts timing, yields no bit.
            state   <= RUN;
            per_cnt <= '0;
          end
        end

        RUN: begin
          if (!en) begin
            state   <= IDLE;
            busy    <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
          end else if (per_timeout) begin
            state   <= ARM;
            per_cnt <= '0;
            shreg   <= '0;
            bit_cnt <= '0;
          end else if (rise && !per_glitch) begin
            per_cnt <= '0;
            shreg   <= byte_next;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ram_data <= byte_next;
              ram_we   <= 1'b1;
            end
          end
          // Glitch edges fall through: counter keeps running, no bit.
        end

        FULL: begin
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Write completes on the clock after the strobe is raised; the
      // address then advances, or the recorder parks in FULL at MAX_ADDR.
      if (ram_we) begin
        byte_count <= byte_count + 16'd1;
        if (ram_addr == MAX_ADDR) begin
          overflow <= 1'b1;
          state    <= FULL;
          busy     <= 1'b0;
        end else begin
          ram_addr <= ram_addr + 16'd1;
        end
      end

      // Rewind is last so it overrides any write or state change above.
      if (rewind) begin
        state      <= IDLE;
        busy       <= 1'b0;
        ram_we     <= 1'b0;
        ram_addr   <= '0;
        byte_count <= '0;
        overflow   <= 1'b0;
        shreg      <= '0;
        bit_cnt    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cas_recorder.sv
module tb_cas_recorder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ce_q;
  logic        en;
  logic        rewind;
  logic [5:0]  dac_in;

  logic [15:0] ram_addr, byte_count;
  logic [7:0]  ram_data;
  logic        ram_we, overflow, busy;

  logic [15:0] ram_addr2, byte_count2;
  logic [7:0]  ram_data2;
  logic        ram_we2, overflow2, busy2;

  always #5 clk = ~clk;

  cas_recorder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce_q       (ce_q),
    .en         (en),
    .rewind     (rewind),
    .dac_in     (dac_in),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .ram_we     (ram_we),
    .byte_count (byte_count),
    .overflow   (overflow),
    .busy       (busy)
  );

  // Small-RAM instance with timing scaled down 10x for the overflow scenario.
  cas_recorder #(
    .MIN_PER  (11'd20),
    .SPLIT    (11'd56),
    .MAX_PER  (11'd150),
    .MAX_ADDR (16'h0002)
  ) dut2 (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce_q       (ce_q),
    .en         (en),
    .rewind     (rewind),
    .dac_in     (dac_in),
    .ram_addr   (ram_addr2),
    .ram_data   (ram_data2),
    .ram_we     (ram_we2),
    .byte_count (byte_count2),
    .overflow   (overflow2),
    .busy       (busy2)
  );

  int vec = 0;
  int err = 0;

  // Write logs, filled only by the monitor below.
  int          wr_n   = 0;
  int          wr2_n  = 0;
  int          consec = 0;
  logic        we_d   = 1'b0;
  logic        we2_d  = 1'b0;
  logic [15:0] wr_addr  [256];
  logic [7:0]  wr_data  [256];
  logic [15:0] wr2_addr [256];
  logic [7:0]  wr2_data [256];

  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      if (wr_n < 256) begin
        wr_addr[wr_n] = ram_addr;
        wr_data[wr_n] = ram_data;
      end
      wr_n++;
    end
    if (ram_we2 === 1'b1) begin
      if (wr2_n < 256) begin
        wr2_addr[wr2_n] = ram_addr2;
        wr2_data[wr2_n] = ram_data2;
      end
      wr2_n++;
    end
    if ((ram_we === 1'b1 && we_d) || (ram_we2 === 1'b1 && we2_d)) consec++;
    we_d  = (ram_we === 1'b1);
    we2_d = (ram_we2 === 1'b1);
  end

  // One Q tick = two clocks, ce_q high across exactly one rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1 ce_q = 1'b1;
      @(posedge clk); #1 ce_q = 1'b0;
    end
  endtask

  task automatic hold(input logic [5:0] v, input int n);
    dac_in = v;
    tick(n);
  endtask

  // One full period starting with its rising edge.
  task automatic period(input int p);
    hold(6'd63, p / 2);
    hold(6'd0, p - p / 2);
  endtask

  task automatic send_byte(input logic [7:0] b, input int p1, input int p0);
    for (int i = 0; i < 8; i++) period(b[i] ? p1 : p0);
  endtask

  task automatic edge_now();
    hold(6'd63, 20);
  endtask

  task automatic restart();
    rewind = 1'b1;
    repeat (2) @(posedge clk);
    #1 rewind = 1'b0;
    hold(6'd0, 5);
  endtask

  task automatic test_reset();
    int b;
    reset_n = 1'b0; en = 1'b0; ce_q = 1'b0; rewind = 1'b0; dac_in = 6'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vec++; if (ram_addr !== 16'h0)   begin err++; $display("FAIL rst_addr got %h want 0000", ram_addr); end
    vec++; if (ram_data !== 8'h0)    begin err++; $display("FAIL rst_data got %h want 00", ram_data); end
    vec++; if (ram_we !== 1'b0)      begin err++; $display("FAIL rst_we got %b want 0", ram_we); end
    vec++; if (byte_count !== 16'h0) begin err++; $display("FAIL rst_count got %h want 0000", byte_count); end
    vec++; if (overflow !== 1'b0)    begin err++; $display("FAIL rst_ovf got %b want 0", overflow); end
    vec++; if (busy !== 1'b0)        begin err++; $display("FAIL rst_busy got %b want 0", busy); end
    #1 reset_n = 1'b1; en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vec++; if (busy !== 1'b1)        begin err++; $display("FAIL arm_busy got %b want 1", busy); end
    // Partial byte (one 0 bit), then reset must drop it.
    b = wr_n;
    #1 hold(6'd0, 5);
    period(746);
    period(746);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vec++; if (busy !== 1'b0)        begin err++; $display("FAIL midrst_busy got %b want 0", busy); end
    vec++; if (wr_n - b !== 0)       begin err++; $display("FAIL midrst_writes got %0d want 0", wr_n - b); end
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Follows test_reset directly, so any kept partial bit would corrupt 8'hFF.
  task automatic test_single_byte();
    int b;
    b = wr_n;
    hold(6'd0, 5);
    send_byte(8'hFF, 372, 372);
    edge_now();
    @(negedge clk);
    vec++; if (wr_n - b !== 1)       begin err++; $display("FAIL ff_writes got %0d want 1", wr_n - b); end
    vec++; if (wr_data[b] !== 8'hFF) begin err++; $display("FAIL ff_data got %h want ff", wr_data[b]); end
    vec++; if (wr_addr[b] !== 16'h0) begin err++; $display("FAIL ff_addr got %h want 0000", wr_addr[b]); end
    vec++; if (byte_count !== 16'd1) begin err++; $display("FAIL ff_count got %0d want 1", byte_count); end
    vec++; if (ram_addr !== 16'd1)   begin err++; $display("FAIL ff_next_addr got %0d want 1", ram_addr); end
  endtask

  task automatic test_mixed_byte();
    int b;
    restart();
    b = wr_n;
    send_byte(8'hAA, 373, 746);
    edge_now();
    @(negedge clk);
    vec++; if (wr_n - b !== 1)       begin err++; $display("FAIL aa_writes got %0d want 1", wr_n - b); end
    vec++; if (wr_data[b] !== 8'hAA) begin err++; $display("FAIL aa_data got %h want aa", wr_data[b]); end
    vec++; if (wr_addr[b] !== 16'h0) begin err++; $display("FAIL aa_addr got %h want 0000", wr_addr[b]); end
  endtask

  task automatic test_timeout();
    int b;
    restart();
    b = wr_n;
    repeat (3) period(372);          // reference + 2 bits, ends low
    for (int i = 0; i < 800; i++) begin
      hold(6'd30, 1);
      hold(6'd34, 1);
    end
    @(negedge clk);
    vec++; if (wr_n - b !== 0)       begin err++; $display("FAIL hyst_writes got %0d want 0", wr_n - b); end
    vec++; if (busy !== 1'b1)        begin err++; $display("FAIL tmo_busy got %b want 1", busy); end
    // Back in ARM: next edge is a fresh reference and the two bits are gone.
    send_byte(8'hF0, 373, 746);
    edge_now();
    @(negedge clk);
    vec++; if (wr_n - b !== 1)       begin err++; $display("FAIL tmo_writes got %0d want 1", wr_n - b); end
    vec++; if (wr_data[b] !== 8'hF0) begin err++; $display("FAIL tmo_data got %h want f0", wr_data[b]); end
    vec++; if (wr_addr[b] !== 16'h0) begin err++; $display("FAIL tmo_addr got %h want 0000", wr_addr[b]); end
  endtask

  task automatic test_glitch_split();
    int b;
    restart();
    b = wr_n;
    // 600-tick period with a spurious rise 199 ticks in -> bit 0.
    hold(6'd63, 100); hold(6'd0, 99); hold(6'd63, 100); hold(6'd0, 301);
    period(560);                     // exactly SPLIT -> 0
    period(559);                     // just under SPLIT -> 1
    repeat (5) period(372);
    edge_now();
    @(negedge clk);
    vec++; if (wr_n - b !== 1)       begin err++; $display("FAIL glitch_writes got %0d want 1", wr_n - b); end
    vec++; if (wr_data[b] !== 8'hFC) begin err++; $display("FAIL glitch_data got %h want fc", wr_data[b]); end
  endtask

  task automatic test_en_drop();
    int b;
    restart();
    b = wr_n;
    send_byte(8'hFF, 372, 372);
    repeat (5) period(746);
    edge_now();                      // 5th bit of the second byte
    en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vec++; if (busy !== 1'b0)        begin err++; $display("FAIL endrop_busy got %b want 0", busy); end
    vec++; if (wr_n - b !== 1)       begin err++; $display("FAIL endrop_writes got %0d want 1", wr_n - b); end
    vec++; if (ram_addr !== 16'd1)   begin err++; $display("FAIL endrop_addr got %0d want 1", ram_addr); end
    vec++; if (byte_count !== 16'd1) begin err++; $display("FAIL endrop_count got %0d want 1", byte_count); end
    #1 hold(6'd0, 5);
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1 send_byte(8'hFF, 372, 372);
    edge_now();
    @(negedge clk);
    vec++; if (wr_n - b !== 2)         begin err++; $display("FAIL resume_writes got %0d want 2", wr_n - b); end
    vec++; if (wr_addr[b+1] !== 16'd1) begin err++; $display("FAIL resume_addr got %0d want 1", wr_addr[b+1]); end
    vec++; if (wr_data[b+1] !== 8'hFF) begin err++; $display("FAIL resume_data got %h want ff", wr_data[b+1]); end
    vec++; if (byte_count !== 16'd2)   begin err++; $display("FAIL resume_count got %0d want 2", byte_count); end
  endtask

  task automatic test_overflow();
    int b;
    restart();
    b = wr2_n;
    send_byte(8'hFF, 37, 74);
    send_byte(8'hFE, 37, 74);
    send_byte(8'h7F, 37, 74);
    send_byte(8'hFF, 37, 74);
    edge_now();
    @(negedge clk);
    vec++; if (wr2_n - b !== 3)         begin err++; $display("FAIL ovf_writes got %0d want 3", wr2_n - b); end
    vec++; if (wr2_addr[b]   !== 16'd0) begin err++; $display("FAIL ovf_addr0 got %0d want 0", wr2_addr[b]); end
    vec++; if (wr2_addr[b+1] !== 16'd1) begin err++; $display("FAIL ovf_addr1 got %0d want 1", wr2_addr[b+1]); end
    vec++; if (wr2_addr[b+2] !== 16'd2) begin err++; $display("FAIL ovf_addr2 got %0d want 2", wr2_addr[b+2]); end
    vec++; if (wr2_data[b]   !== 8'hFF) begin err++; $display("FAIL ovf_data0 got %h want ff", wr2_data[b]); end
    vec++; if (wr2_data[b+1] !== 8'hFE) begin err++; $display("FAIL ovf_data1 got %h want fe", wr2_data[b+1]); end
    vec++; if (wr2_data[b+2] !== 8'h7F) begin err++; $display("FAIL ovf_data2 got %h want 7f", wr2_data[b+2]); end
    vec++; if (overflow2 !== 1'b1)      begin err++; $display("FAIL ovf_flag got %b want 1", overflow2); end
    vec++; if (ram_addr2 !== 16'd2)     begin err++; $display("FAIL ovf_addr got %0d want 2", ram_addr2); end
    vec++; if (byte_count2 !== 16'd3)   begin err++; $display("FAIL ovf_count got %0d want 3", byte_count2); end
    vec++; if (busy2 !== 1'b0)          begin err++; $display("FAIL ovf_busy got %b want 0", busy2); end
  endtask

  task automatic test_rewind_priority();
    int b;
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1 hold(6'd0, 5);
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1 b = wr_n;
    send_byte(8'hFF, 372, 372);
    send_byte(8'hFF, 372, 372);
    @(negedge clk);
    vec++; if (byte_count !== 16'd1) begin err++; $display("FAIL pre_rew_count got %0d want 1", byte_count); end
    vec++; if (overflow2 !== 1'b1)   begin err++; $display("FAIL pre_rew_ovf got %b want 1", overflow2); end
    // 8th bit of the second byte and rewind on the same clock.
    #1 dac_in = 6'd63;
    @(posedge clk); #1 ce_q = 1'b1; rewind = 1'b1;
    @(posedge clk); #1 ce_q = 1'b0; rewind = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    vec++; if (wr_n - b !== 1)        begin err++; $display("FAIL rew_writes got %0d want 1", wr_n - b); end
    vec++; if (ram_addr !== 16'h0)    begin err++; $display("FAIL rew_addr got %h want 0000", ram_addr); end
    vec++; if (byte_count !== 16'h0)  begin err++; $display("FAIL rew_count got %h want 0000", byte_count); end
    vec++; if (overflow !== 1'b0)     begin err++; $display("FAIL rew_ovf got %b want 0", overflow); end
    vec++; if (overflow2 !== 1'b0)    begin err++; $display("FAIL rew_ovf2 got %b want 0", overflow2); end
    vec++; if (byte_count2 !== 16'h0) begin err++; $display("FAIL rew_count2 got %h want 0000", byte_count2); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_mixed_byte();
    test_timeout();
    test_glitch_split();
    test_en_drop();
    test_overflow();
    test_rewind_priority();
    vec++; if (consec !== 0) begin err++; $display("FAIL we_back_to_back got %0d want 0", consec); end
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/cas_recorder.md
CAS_RECORDER -- requirements
Module: cas_recorder

Interface
REQ-001 SHALL provide parameter THRESH, default 6'd32: DAC comparator midpoint.
REQ-002 SHALL provide parameter HYST, default 6'd4: comparator hysteresis half-width.
REQ-003 SHALL provide parameter MIN_PER, default 11'd200: shortest accepted period, in ce_q ticks.
REQ-004 SHALL provide parameter SPLIT, default 11'd560: bit decision threshold, in ce_q ticks.
REQ-005 SHALL provide parameter MAX_PER, default 11'd1500: gap timeout, in ce_q ticks.
REQ-006 SHALL provide parameter MAX_ADDR, default 16'hFFFF: last writable RAM address.
REQ-007 clk  input  1  system clock (clk_sys); all logic on its rising edge.
REQ-008 reset_n  input  1  reset, synchronous, active-low.
REQ-009 ce_q  input  1  one-clk-wide pulse per CoCo Q cycle (~0.895 MHz), from clk_Q_out.
REQ-010 en  input  1  cassette motor relay (cas_relay); 1 = recording allowed.
REQ-011 rewind  input  1  level; 1 = clear address, count and flags.
REQ-012 dac_in  input  6  CoCo 6-bit sound DAC output (cassette-out signal).
REQ-013 ram_addr  output  16  write address into the cassette SRAM.
REQ-014 ram_data  output  8  byte to write.
REQ-015 ram_we  output  1  one-clk write strobe, active high.
REQ-016 byte_count  output  16  number of bytes written since the last rewind or reset.
REQ-017 overflow  output  1  sticky; set when the byte at MAX_ADDR has been written.
REQ-018 busy  output  1  high in state ARM or RUN.

Function
REQ-019 Comparator SHALL update only on ce_q: level goes to 1 when dac_in >= THRESH+HYST, goes to 0 when dac_in <= THRESH-HYST, and otherwise holds.
REQ-020 A rising edge SHALL be a 0->1 change of level, detected on a ce_q cycle.
REQ-021 Period counter SHALL be 11 bits, increment on ce_q, saturate at 2047, and clear to 0 on every accepted edge.
REQ-022 An edge with period < MIN_PER SHALL be discarded as a glitch: the counter keeps counting and no bit is produced.
REQ-023 An accepted edge with MIN_PER <= period < SPLIT SHALL produce bit 1 (2400 Hz); period >= SPLIT SHALL produce bit 0 (1200 Hz).
REQ-024 Bits SHALL be shifted into the byte LSB first; a 3-bit counter tracks bit position.
REQ-025 On the 8th bit, ram_data SHALL take the assembled byte and ram_we SHALL pulse on the following clk.
REQ-026 On that following clk, ram_addr and byte_count SHALL each increment by 1.
REQ-027 State machine SHALL have four states: IDLE, ARM, RUN, FULL.
REQ-028 IDLE->ARM when en=1; the period counter clears on entry.
REQ-029 ARM->RUN on the first rising edge; that edge is a timing reference only and produces no bit.
REQ-030 RUN->ARM when the period counter reaches MAX_PER; the partial byte is discarded and the bit counter cleared.
REQ-031 ARM/RUN->IDLE when en=0; the partial byte is discarded, and ram_addr and byte_count are retained.
REQ-032 A write at ram_addr == MAX_ADDR SHALL set overflow and move to FULL; ram_addr stays at MAX_ADDR.
REQ-033 In FULL, no further ram_we SHALL be issued.
REQ-034 Rewind SHALL clear ram_addr, byte_count, overflow, shift register and bit counter, and go to IDLE.
REQ-035 Rewind SHALL have priority over any same-cycle write or state change; the write is suppressed.
REQ-036 ram_we SHALL never be high on two consecutive clk cycles.

Reset
REQ-037 While reset_n=0 at a clk edge, all registers SHALL clear: ram_addr=0, ram_data=0, ram_we=0, byte_count=0, overflow=0, busy=0, level=0, counters=0, state=IDLE.
REQ-038 Reset mid-byte SHALL discard the partial byte with no write.

Verification
REQ-039 en=1; square wave on dac_in (0/63), half-periods 186/186 ticks; 1 reference edge then 8 periods -> single ram_we, ram_data=8'hFF, ram_addr=0, then byte_count=1.
REQ-040 Reference edge then periods 746,373,746,373,746,373,746,373 -> ram_data=8'hAA, written at address 0.
REQ-041 dac_in toggles 30<->34 (inside the hysteresis band) -> no edges, no ram_we; with en=1 and no edges for 1500 ticks in RUN -> state ARM, partial byte dropped.
REQ-042 MAX_ADDR=16'h0002; feed 4 bytes -> 3 writes (addresses 0,1,2), overflow=1, state FULL, 4th byte not written.
REQ-043 Rewind asserted on the cycle the 8th bit completes -> no ram_we, ram_addr=0, byte_count=0, overflow=0.
REQ-044 en dropped after 5 bits -> IDLE, no write, ram_addr unchanged; next byte lands at the same address.
